// File: rtl/load_store_unit.sv
// Load/store unit: aligns CPU byte/half/word accesses onto a 32-bit word bus
// with one outstanding request, lane enables, load extension and a ready timeout.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    input  logic [2:0]            cpu_mem_fn,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_write_data,
    output logic [31:0]           cpu_read_data,
    output logic                  cpu_stall,
    output logic                  cpu_misaligned,
    output logic                  cpu_bus_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_read_data
);

    // Access-type encodings shared with the pipeline decoder.
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_SB  = 3'b011;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;
    localparam logic [2:0] MEM_SH  = 3'b110;
    localparam logic [2:0] MEM_SW  = 3'b111;

    // Counter only ever holds 0..TIMEOUT_CYCLES-1 before leaving BUSY.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              fn_q, fn_d;
    logic [1:0]              off_q, off_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [3:0]              be_q, be_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    byte_c, half_c, store_c, misaligned_c;
    logic [3:0]              be_c;
    logic [31:0]             wdata_c;
    logic [7:0]              lbyte_c;
    logic [15:0]             lhalf_c;
    logic [31:0]             load_c;

    // Decode the incoming access: size, direction, alignment, lanes and store data.
    always_comb begin
        byte_c       = (cpu_mem_fn == MEM_LB) || (cpu_mem_fn == MEM_LBU) || (cpu_mem_fn == MEM_SB);
        half_c       = (cpu_mem_fn == MEM_LH) || (cpu_mem_fn == MEM_LHU) || (cpu_mem_fn == MEM_SH);
        store_c      = (cpu_mem_fn == MEM_SB) || (cpu_mem_fn == MEM_SH) || (cpu_mem_fn == MEM_SW);
        misaligned_c = (half_c && cpu_addr[0]) ||
                       (!byte_c && !half_c && (cpu_addr[1:0] != 2'b00));
        if (byte_c) begin
            be_c    = 4'b0001 << cpu_addr[1:0];
            wdata_c = {4{cpu_write_data[7:0]}};
        end else if (half_c) begin
            be_c    = cpu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{cpu_write_data[15:0]}};
        end else begin
            be_c    = 4'b1111;
            wdata_c = cpu_write_data;
        end
    end

    // Pick the addressed byte/half of the returned word and extend it per the latched access.
    always_comb begin
        case (off_q)
            2'd0:    lbyte_c = mem_read_data[7:0];
            2'd1:    lbyte_c = mem_read_data[15:8];
            2'd2:    lbyte_c = mem_read_data[23:16];
            default: lbyte_c = mem_read_data[31:24];
        endcase
        lhalf_c = off_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (fn_q)
            MEM_LB:  load_c = {{24{lbyte_c[7]}}, lbyte_c};
            MEM_LBU: load_c = {24'd0, lbyte_c};
            MEM_LH:  load_c = {{16{lhalf_c[15]}}, lhalf_c};
            MEM_LHU: load_c = {16'd0, lhalf_c};
            MEM_LW:  load_c = mem_read_data;
            default: load_c = 32'd0;
        endcase
    end

    // Next-state and next-register logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        fn_d    = fn_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_valid && !misaligned_c) begin
                    state_d = ST_BUSY;
                    fn_d    = cpu_mem_fn;
                    off_d   = cpu_addr[1:0];
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = store_c;
                    be_d    = be_c;
                    addr_d  = cpu_addr[ADDR_WIDTH+1:2];
                    wdata_d = wdata_c;
                end
            end
            ST_BUSY: begin
                if (mem_ready || ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST))) begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    state_d = ST_DONE;
                    rdata_d = mem_ready ? load_c : 32'd0;
                    err_d   = !mem_ready;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'd0;
                    addr_d  = '0;
                    wdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rdata_d = 32'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fn_q    <= 3'd0;
            off_q   <= 2'd0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fn_q    <= fn_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stall and misalignment answer the pipeline within the request cycle.
    assign cpu_stall      = !rst && (((state_q == ST_IDLE) && cpu_valid && !misaligned_c) ||
                                     (state_q == ST_BUSY));
    assign cpu_misaligned = !rst && (state_q == ST_IDLE) && cpu_valid && misaligned_c;

    assign cpu_read_data  = rdata_q;
    assign cpu_bus_error  = err_q;
    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_be         = be_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic access model.
module tb_load_store_unit;

    localparam int unsigned AW = 30;
    localparam int unsigned TO = 4;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] SB  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SH  = 3'b110;
    localparam logic [2:0] SW  = 3'b111;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid;
    logic [2:0]    cpu_mem_fn;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_write_data;
    logic [31:0]   cpu_read_data;
    logic          cpu_stall;
    logic          cpu_misaligned;
    logic          cpu_bus_error;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic          mem_ready;
    logic [31:0]   mem_read_data;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_mem_fn(cpu_mem_fn), .cpu_addr(cpu_addr),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
        .cpu_stall(cpu_stall), .cpu_misaligned(cpu_misaligned), .cpu_bus_error(cpu_bus_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and the rules derived from it.
    function automatic int unsigned fn_size(input logic [2:0] fn);
        if (fn == LB || fn == LBU || fn == SB) return 1;
        if (fn == LH || fn == LHU || fn == SH) return 2;
        return 4;
    endfunction

    function automatic bit is_store(input logic [2:0] fn);
        return (fn == SB || fn == SH || fn == SW);
    endfunction

    function automatic bit is_mis(input logic [2:0] fn, input logic [31:0] addr);
        return (addr % fn_size(fn)) != 0;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] fn, input logic [31:0] addr);
        int unsigned sz;
        int unsigned off;
        sz  = fn_size(fn);
        off = addr % 4;
        return 32'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] fn, input logic [31:0] wd);
        int unsigned sz;
        sz = fn_size(fn);
        if (sz == 1) return (wd % 256) * 32'h0101_0101;
        if (sz == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] fn, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int unsigned sz;
        int unsigned off;
        longint      v;
        sz  = fn_size(fn);
        off = addr % 4;
        if (is_store(fn)) return 32'd0;
        if (sz == 4) return rd;
        v = longint'(rd >> (8 * off)) % (longint'(1) << (8 * sz));
        if ((fn == LB || fn == LH) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    // One complete access: request cycle, BUSY with a given number of unready cycles, DONE.
    task automatic access(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits, input bit tail);
        bit          mis;
        bit          timed_out;
        bit          rdy;
        bit          leave;
        int          busy;
        int          stalls;
        logic [31:0] exp_rd;
        mis       = is_mis(fn, addr);
        timed_out = (waits >= int'(TO));
        exp_rd    = timed_out ? 32'd0 : model_load(fn, addr, rd);

        cpu_valid = 1'b1; cpu_mem_fn = fn; cpu_addr = addr; cpu_write_data = wd;
        mem_ready = 1'b0; mem_read_data = $urandom;
        @(negedge clk);
        check("req_stall", cpu_stall, !mis);
        check("req_misaligned", cpu_misaligned, mis);
        check("req_no_mem_req", mem_req, 0);
        stalls = int'(cpu_stall);
        @(posedge clk); #1;

        if (mis) begin
            cpu_valid = 1'b0;
            @(negedge clk);
            check("mis_no_mem_req", mem_req, 0);
            check("mis_no_stall", cpu_stall, 0);
            @(posedge clk); #1;
            return;
        end

        busy  = 0;
        leave = 1'b0;
        while (!leave) begin
            rdy = (busy == waits);
            cpu_valid = 1'b0; cpu_mem_fn = 3'($urandom); cpu_addr = $urandom;
            cpu_write_data = $urandom;
            mem_ready = rdy; mem_read_data = rdy ? rd : $urandom;
            @(negedge clk);
            check("busy_req", mem_req, 1);
            check("busy_we", mem_we, is_store(fn));
            check("busy_be", mem_be, model_be(fn, addr));
            check("busy_addr", mem_addr, addr / 4);
            check("busy_wdata", mem_write_data, is_store(fn) ? model_wdata(fn, wd) : mem_write_data & 32'h0 | model_wdata(fn, wd));
            check("busy_stall", cpu_stall, 1);
            stalls += int'(cpu_stall);
            @(posedge clk); #1;
            busy++;
            if (rdy || busy == int'(TO)) leave = 1'b1;
        end

        // DONE: new requests and a stray ready must both be ignored.
        cpu_valid = 1'b1; cpu_mem_fn = SW; cpu_addr = 32'h0; mem_ready = 1'b1;
        mem_read_data = $urandom;
        @(negedge clk);
        check("done_stall", cpu_stall, 0);
        check("done_rdata", cpu_read_data, exp_rd);
        check("done_bus_error", cpu_bus_error, timed_out);
        check("done_mem_req", mem_req, 0);
        check("stall_cycles", stalls, 1 + busy);
        @(posedge clk); #1;

        if (tail) begin
            cpu_valid = 1'b0; mem_ready = 1'b1;
            @(negedge clk);
            check("idle_mem_req", mem_req, 0);
            check("idle_stall", cpu_stall, 0);
            check("idle_bus_error", cpu_bus_error, 0);
            check("idle_rdata", cpu_read_data, 0);
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  fns [8];
        logic [31:0] a;
        fns = '{LB, LH, LW, SB, LBU, LHU, SH, SW};

        // Reset with a misaligned request present: flags must stay low.
        rst = 1'b1; cpu_valid = 1'b1; cpu_mem_fn = LW; cpu_addr = 32'h6;
        cpu_write_data = 32'h0; mem_ready = 1'b1; mem_read_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_stall", cpu_stall, 0);
        check("rst_misaligned", cpu_misaligned, 0);
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_rdata", cpu_read_data, 0);
        check("rst_bus_error", cpu_bus_error, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;

        // Signed byte load from the top lane, zero-wait memory.
        access(LB, 32'h103, 32'h0, 32'h80FF_FF12, 0, 1'b1);
        // Halfword store held across three unready cycles.
        access(SH, 32'h202, 32'h1234_ABCD, 32'h0, 3, 1'b1);
        // Misaligned word load.
        access(LW, 32'h6, 32'h0, 32'h0, 0, 1'b1);
        // Timeout on an unsigned halfword load.
        access(LHU, 32'h2, 32'h0, 32'h0, 4, 1'b1);

        // Reset while BUSY abandons the access; the later ready is ignored.
        cpu_valid = 1'b1; cpu_mem_fn = LW; cpu_addr = 32'h10; mem_ready = 1'b0;
        @(negedge clk);
        check("rb_req_stall", cpu_stall, 1);
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        @(negedge clk);
        check("rb_busy_req", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rb_rst_stall", cpu_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; mem_read_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rb_after_req", mem_req, 0);
        check("rb_after_stall", cpu_stall, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("rb_no_done_rdata", cpu_read_data, 0);
        check("rb_no_done_err", cpu_bus_error, 0);
        check("rb_no_done_req", mem_req, 0);
        @(posedge clk); #1;

        // Back-to-back: store word then byte load issued right after DONE.
        access(SW, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
        access(LBU, 32'h1, 32'h0, 32'h0000_AB00, 0, 1'b1);

        // Randomized accesses, including misaligned, ready-at-limit and timeouts.
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            access(fns[$urandom_range(0, 7)], a, $urandom, $urandom,
                   int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
